// File: rtl/lvds_capture_pkg.sv
// Shared types and helpers for the multi-channel LVDS capture buffer.
package lvds_capture_pkg;

  // Capture controller states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_e;

  // Width of an index over n items, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lvds_capture_chan.sv
// One capture channel: LSB-first bit packer feeding a WORDS x RD_W
// simple dual-port RAM with a registered (read-first) read port.
module lvds_capture_chan #(
  parameter int RD_W  = 32,
  parameter int WORDS = 128,
  parameter int AW    = 7,
  parameter int BW    = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            bit_in,
  input  logic            shift_en,
  input  logic [BW-1:0]   bit_idx,
  input  logic            clear,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_addr,
  output logic [RD_W-1:0] rd_word
);

  // Only the first RD_W-1 bits need holding; the last bit goes straight
  // into the word written to memory.
  logic [RD_W-2:0] pack_q, pack_d;
  logic [RD_W-1:0] wr_word;
  logic [RD_W-1:0] mem [WORDS];
  logic [RD_W-1:0] rd_word_q;

  assign wr_word = {bit_in, pack_q};
  assign rd_word = rd_word_q;

  // Place each accepted bit at its position within the word being built.
  always_comb begin
    pack_d = pack_q;
    if (clear) begin
      pack_d = '0;
    end else if (shift_en && (bit_idx != BW'(RD_W - 1))) begin
      pack_d[bit_idx] = bit_in;
    end
  end

  // Packer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pack_q <= '0;
    end else begin
      pack_q <= pack_d;
    end
  end

  // Word memory write port; contents are deliberately never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_word;
    end
  end

  // Registered read port: a same-cycle write to the same word returns old data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_word_q <= '0;
    end else if (rd_en) begin
      rd_word_q <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/lvds_capture_buffer.sv
// Multi-channel LVDS capture buffer: arm/trigger/length controller, shared
// bit counter and write pointer, per-channel packers and RAMs, read mux.
module lvds_capture_buffer
  import lvds_capture_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int DEPTH  = 4096,
  parameter  int RD_W   = 32,
  localparam int WORDS  = DEPTH / RD_W,
  localparam int AW     = clog2_min1(WORDS),
  localparam int CW     = $clog2(WORDS) + 1,
  localparam int SW     = clog2_min1(NUM_CH),
  localparam int BW     = clog2_min1(RD_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] in_data,
  input  logic              in_valid,
  input  logic              arm,
  input  logic              abort,
  input  logic              trig,
  input  logic [CW-1:0]     cap_len,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  input  logic [SW-1:0]     rd_sel,
  output logic [RD_W-1:0]   rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic [CW-1:0]     wr_words
);

  localparam logic [CW-1:0] WORDS_C = CW'(WORDS);

  cap_state_e      state_q, state_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]   wr_words_q, wr_words_d;
  logic [CW-1:0]   len_q, len_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            rd_valid_q, rd_valid_d;
  logic [SW-1:0]   rd_sel_q, rd_sel_d;

  logic            arm_ok;
  logic            take;
  logic            word_end;
  logic            final_word;
  logic            pack_clear;
  logic [CW-1:0]   eff_len;
  logic [AW-1:0]   wr_addr;

  logic [RD_W-1:0] word_mux [2**SW];

  assign wr_addr  = wr_words_q[AW-1:0];
  assign busy     = busy_q;
  assign done     = done_q;
  assign wr_words = wr_words_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = word_mux[rd_sel_q];

  // Controller next state: abort beats arm, arm beats trigger; a trigger only
  // counts together with a valid sample, which becomes bit 0 of word 0.
  always_comb begin
    arm_ok     = arm && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    take       = !abort && in_valid &&
                 (((state_q == ST_ARMED) && trig) || (state_q == ST_CAPTURE));
    word_end   = take && (bit_cnt_q == BW'(RD_W - 1));
    final_word = word_end && ((wr_words_q + CW'(1)) == len_q);
    eff_len    = ((cap_len == '0) || (cap_len > WORDS_C)) ? WORDS_C : cap_len;
    pack_clear = abort || arm_ok;

    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    wr_words_d = wr_words_q;
    len_d      = len_q;

    if (abort) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
    end else if (arm_ok) begin
      state_d    = ST_ARMED;
      bit_cnt_d  = '0;
      wr_words_d = '0;
      len_d      = eff_len;
    end else if (take) begin
      bit_cnt_d = bit_cnt_q + BW'(1);
      state_d   = final_word ? ST_DONE : ST_CAPTURE;
      if (word_end) begin
        wr_words_d = wr_words_q + CW'(1);
      end
    end

    busy_d     = (state_d == ST_ARMED) || (state_d == ST_CAPTURE);
    done_d     = (state_d == ST_DONE);
    rd_valid_d = rd_en;
    rd_sel_d   = rd_en ? rd_sel : rd_sel_q;
  end

  // Controller, counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      wr_words_q <= '0;
      len_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_sel_q   <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      wr_words_q <= wr_words_d;
      len_q      <= len_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_sel_q   <= rd_sel_d;
    end
  end

  // One packer/RAM per channel; unused select codes read as zero.
  generate
    for (genvar gi = 0; gi < 2**SW; gi++) begin : g_chan
      if (gi < NUM_CH) begin : g_used
        lvds_capture_chan #(
          .RD_W  (RD_W),
          .WORDS (WORDS),
          .AW    (AW),
          .BW    (BW)
        ) u_chan (
          .clk      (clk),
          .rst      (rst),
          .bit_in   (in_data[gi]),
          .shift_en (take),
          .bit_idx  (bit_cnt_q),
          .clear    (pack_clear),
          .wr_en    (word_end),
          .wr_addr  (wr_addr),
          .rd_en    (rd_en),
          .rd_addr  (rd_addr),
          .rd_word  (word_mux[gi])
        );
      end else begin : g_unused
        assign word_mux[gi] = '0;
      end
    end
  endgenerate

endmodule
